// File: rtl/tpu_apb_sequencer.sv
// APB master that runs write, read and poll-until-mask commands against the TPU register port.
// Define TPU_SEQ_TIMEOUT_EN to compile in the MAX_POLLS poll timeout (status 01).
module tpu_apb_sequencer #(
    parameter int unsigned REG_ADDRWIDTH = 8,
    parameter int unsigned REG_DATAWIDTH = 32,
    parameter int unsigned POLL_GAP      = 4,
    parameter int unsigned MAX_POLLS     = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_kind,
    input  logic [REG_ADDRWIDTH-1:0] cmd_addr,
    input  logic [REG_DATAWIDTH-1:0] cmd_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [1:0]               resp_status,
    output logic [REG_DATAWIDTH-1:0] resp_rdata,
    output logic                     busy,
    output logic [REG_ADDRWIDTH-1:0] PADDR,
    output logic                     PWRITE,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic [REG_DATAWIDTH-1:0] PWDATA,
    input  logic [REG_DATAWIDTH-1:0] PRDATA,
    input  logic                     PREADY
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [1:0] KIND_WRITE   = 2'b00;
    localparam logic [1:0] KIND_POLL    = 2'b10;
    localparam logic [1:0] KIND_RSVD    = 2'b11;
    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_ILLEGAL = 2'b10;

    // Zero-valued POLL_GAP or MAX_POLLS is not a supported configuration.
    if (POLL_GAP == 0 || MAX_POLLS == 0) begin : g_unsupported_config
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP,
        S_RESP
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               kind_q, kind_d;
    logic [REG_ADDRWIDTH-1:0] addr_q, addr_d;
    logic [REG_DATAWIDTH-1:0] data_q, data_d;
    logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
    logic                     psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic                     pwrite_q, pwrite_d;
    logic [REG_ADDRWIDTH-1:0] paddr_q, paddr_d;
    logic [REG_DATAWIDTH-1:0] pwdata_q, pwdata_d;
    logic                     resp_valid_q, resp_valid_d;
    logic [1:0]               resp_status_q, resp_status_d;
    logic [REG_DATAWIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                     poll_hit;

`ifdef TPU_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_POLLS + 1);
    logic [CNT_W-1:0]         poll_cnt_q, poll_cnt_d;
`endif

    assign cmd_ready   = (state_q == S_IDLE) & ~reset;
    assign busy        = (state_q != S_IDLE);
    assign poll_hit    = (PRDATA & data_q) != '0;

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign resp_valid  = resp_valid_q;
    assign resp_status = resp_status_q;
    assign resp_rdata  = resp_rdata_q;

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        addr_d        = addr_q;
        data_d        = data_q;
        gap_cnt_d     = gap_cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        resp_valid_d  = resp_valid_q;
        resp_status_d = resp_status_q;
        resp_rdata_d  = resp_rdata_q;
`ifdef TPU_SEQ_TIMEOUT_EN
        poll_cnt_d    = poll_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    kind_d       = cmd_kind;
                    addr_d       = cmd_addr;
                    data_d       = cmd_data;
                    resp_rdata_d = '0;
`ifdef TPU_SEQ_TIMEOUT_EN
                    poll_cnt_d   = '0;
`endif
                    if (cmd_kind == KIND_RSVD) begin
                        state_d       = S_RESP;
                        resp_valid_d  = 1'b1;
                        resp_status_d = STAT_ILLEGAL;
                    end else begin
                        state_d   = S_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = cmd_addr;
                        pwrite_d  = (cmd_kind == KIND_WRITE);
                        pwdata_d  = (cmd_kind == KIND_WRITE) ? cmd_data : '0;
                    end
                end
            end

            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end

            // Everything on the bus stays put until the slave completes; PSEL
            // is released on the way out whether we respond or go idle in GAP.
            S_ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (kind_q != KIND_WRITE) begin
                        resp_rdata_d = PRDATA;
                    end
                    if (kind_q != KIND_POLL || poll_hit) begin
                        state_d       = S_RESP;
                        resp_valid_d  = 1'b1;
                        resp_status_d = STAT_OK;
                    end else begin
`ifdef TPU_SEQ_TIMEOUT_EN
                        poll_cnt_d = poll_cnt_q + CNT_W'(1);
                        if (poll_cnt_q == CNT_W'(MAX_POLLS - 1)) begin
                            state_d       = S_RESP;
                            resp_valid_d  = 1'b1;
                            resp_status_d = 2'b01;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end
`else
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
`endif
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d   = S_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = addr_q;
                    pwrite_d  = 1'b0;
                    pwdata_d  = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            kind_q        <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            gap_cnt_q     <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= '0;
            resp_rdata_q  <= '0;
`ifdef TPU_SEQ_TIMEOUT_EN
            poll_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            gap_cnt_q     <= gap_cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_rdata_q  <= resp_rdata_d;
`ifdef TPU_SEQ_TIMEOUT_EN
            poll_cnt_q    <= poll_cnt_d;
`endif
        end
    end

endmodule
